// File: rtl/memctl_pkg.sv
// Shared memory-controller types: refill FSM states, block geometry, block alignment.
// No logic of its own; latency n/a.
// Backpressure n/a.
package memctl_pkg;

    localparam int ADDR_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        RD_REQ,
        RD_WAIT,
        DONE
    } refill_state_t;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr,
                                                     input int unsigned offset_bits);
        logic [ADDR_W-1:0] mask;
        mask = '1 << offset_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/block_refill_engine.sv
// Splits L1 block refills/write-backs into single-word RAM transactions, reassembles refills.
// Latency: 1 cycle request to first ram_req; 2 cycles/read word, 1 cycle/write word, +1 DONE pulse.
// Backpressure: ram_ready low holds the current word with all ram_* outputs stable.
module block_refill_engine
    import memctl_pkg::*;
#(
    parameter int WA             = 32,
    parameter int WD             = 32,
    parameter int BLOCKSIZE      = 128,
    parameter int BYTE_ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic [WA-1:0]        mem_request_addr,
    input  logic                 mem_write,
    input  logic [WA-1:0]        mem_wb_addr,
    input  logic [BLOCKSIZE-1:0] mem_write_data,
    output logic                 memory_ready,
    output logic [BLOCKSIZE-1:0] memory_data,
    output logic                 busy,
    output logic                 ram_req,
    output logic                 ram_we,
    output logic [WA-1:0]        ram_addr,
    output logic [WD-1:0]        ram_wdata,
    input  logic                 ram_ready,
    input  logic                 ram_rvalid,
    input  logic [WD-1:0]        ram_rdata
);

    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

    refill_state_t        state;
    logic [1:0]           cnt;
    logic [1:0]           cnt_nxt;
    logic [WA-1:0]        wb_base;
    logic [WA-1:0]        rd_base;
    logic [BLOCKSIZE-1:0] wb_data;
    logic                 rd_pending;

    function automatic logic [WA-1:0] word_addr(input logic [WA-1:0] base, input logic [1:0] k);
        return base + WA'(k) * WA'(WD / 8);
    endfunction

    assign cnt_nxt = cnt + 2'd1;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_base      <= '0;
            rd_base      <= '0;
            wb_data      <= '0;
            rd_pending   <= 1'b0;
            ram_req      <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            memory_ready <= 1'b0;
            memory_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    memory_ready <= 1'b0;
                    cnt          <= '0;
                    // Write-back is issued before the refill so a read of the evicted block sees the new data.
                    if (mem_write) begin
                        wb_base    <= block_base(mem_wb_addr, BYTE_ADDR_BITS);
                        wb_data    <= mem_write_data;
                        rd_pending <= mem_read;
                        rd_base    <= block_base(mem_request_addr, BYTE_ADDR_BITS);
                        ram_req    <= 1'b1;
                        ram_we     <= 1'b1;
                        ram_addr   <= block_base(mem_wb_addr, BYTE_ADDR_BITS);
                        ram_wdata  <= mem_write_data[WD-1:0];
                        state      <= WB_REQ;
                    end else if (mem_read) begin
                        rd_pending <= 1'b0;
                        rd_base    <= block_base(mem_request_addr, BYTE_ADDR_BITS);
                        ram_req    <= 1'b1;
                        ram_we     <= 1'b0;
                        ram_addr   <= block_base(mem_request_addr, BYTE_ADDR_BITS);
                        state      <= RD_REQ;
                    end
                end
                WB_REQ: begin
                    if (ram_ready) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST_WORD) begin
                            ram_we <= 1'b0;
                            if (rd_pending) begin
                                ram_addr <= rd_base;
                                state    <= RD_REQ;
                            end else begin
                                ram_req      <= 1'b0;
                                memory_ready <= 1'b1;
                                state        <= DONE;
                            end
                        end else begin
                            ram_addr  <= word_addr(wb_base, cnt_nxt);
                            ram_wdata <= wb_data[WD*cnt_nxt +: WD];
                        end
                    end
                end
                RD_REQ: begin
                    if (ram_ready) begin
                        ram_req <= 1'b0;
                        state   <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ram_rvalid) begin
                        memory_data[WD*cnt +: WD] <= ram_rdata;
                        cnt                       <= cnt_nxt;
                        if (cnt == LAST_WORD) begin
                            memory_ready <= 1'b1;
                            state        <= DONE;
                        end else begin
                            ram_req  <= 1'b1;
                            ram_addr <= word_addr(rd_base, cnt_nxt);
                            state    <= RD_REQ;
                        end
                    end
                end
                DONE: begin
                    memory_ready <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_refill_engine.sv
// Directed bench for block_refill_engine with a word-RAM model (stall and read-latency knobs).
// Latency: n/a.
// Backpressure: ram_ready stalled by address match from the model.
module tb_block_refill_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic [31:0]  mem_request_addr;
    logic         mem_write;
    logic [31:0]  mem_wb_addr;
    logic [127:0] mem_write_data;
    logic         memory_ready;
    logic [127:0] memory_data;
    logic         busy;
    logic         ram_req;
    logic         ram_we;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic         ram_ready;
    logic         ram_rvalid;
    logic [31:0]  ram_rdata;

    // model controls, written only by the stimulus block
    int          rd_lat;
    logic [31:0] stall_addr;
    int          stall_cfg;
    logic        stall_load;
    logic        spur_vld;

    // model state, written only by the model
    logic [31:0] mem_arr [0:255];
    logic        wr_v    [0:255];
    logic        mdl_rvalid;
    logic [31:0] mdl_rdata;
    logic        pend;
    int          wait_left;
    logic [31:0] pend_data;
    int          stall_left;
    logic [31:0] log_addr [$];
    logic        log_we   [$];
    logic [31:0] log_data [$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    block_refill_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read         (mem_read),
        .mem_request_addr (mem_request_addr),
        .mem_write        (mem_write),
        .mem_wb_addr      (mem_wb_addr),
        .mem_write_data   (mem_write_data),
        .memory_ready     (memory_ready),
        .memory_data      (memory_data),
        .busy             (busy),
        .ram_req          (ram_req),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_ready        (ram_ready),
        .ram_rvalid       (ram_rvalid),
        .ram_rdata        (ram_rdata)
    );

    function automatic logic [7:0] midx(input logic [31:0] a);
        return {a[13:12], a[7:2]};
    endfunction

    // Unwritten words around 0x1230 hold 0xA0..0xA3.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (wr_v[midx(a)]) return mem_arr[midx(a)];
        if (a[31:4] == 28'h0000123) return 32'hA0 + {30'd0, a[3:2]};
        return 32'h0;
    endfunction

    assign ram_ready  = !(ram_req && ram_addr == stall_addr && stall_left != 0);
    assign ram_rvalid = mdl_rvalid | spur_vld;
    assign ram_rdata  = spur_vld ? 32'h0000DEAD : mdl_rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) wr_v[i] <= 1'b0;
            mdl_rvalid <= 1'b0;
            mdl_rdata  <= 32'h0;
            pend       <= 1'b0;
            wait_left  <= 0;
            pend_data  <= 32'h0;
            stall_left <= 0;
        end else begin
            mdl_rvalid <= 1'b0;
            if (stall_load) stall_left <= stall_cfg;
            else if (ram_req && ram_addr == stall_addr && stall_left != 0) stall_left <= stall_left - 1;
            if (pend) begin
                if (wait_left == 0) begin
                    mdl_rvalid <= 1'b1;
                    mdl_rdata  <= pend_data;
                    pend       <= 1'b0;
                end else begin
                    wait_left <= wait_left - 1;
                end
            end
            if (ram_req && ram_ready) begin
                log_addr.push_back(ram_addr);
                log_we.push_back(ram_we);
                log_data.push_back(ram_wdata);
                if (ram_we) begin
                    mem_arr[midx(ram_addr)] <= ram_wdata;
                    wr_v[midx(ram_addr)]    <= 1'b1;
                end else if (rd_lat == 0) begin
                    mdl_rvalid <= 1'b1;
                    mdl_rdata  <= mem_rd(ram_addr);
                end else begin
                    pend      <= 1'b1;
                    wait_left <= rd_lat - 1;
                    pend_data <= mem_rd(ram_addr);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request at a negedge; returns at the negedge of cycle 1 with requests dropped.
    task automatic issue(input logic rd, input logic [31:0] ra, input logic wr,
                         input logic [31:0] wa, input logic [127:0] wd);
        mem_read         = rd;
        mem_request_addr = ra;
        mem_write        = wr;
        mem_wb_addr      = wa;
        mem_write_data   = wd;
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic wait_ready(input int start, input int budget, input logic [31:0] watch,
                              output int cyc, output int seen);
        cyc  = start;
        seen = 0;
        while (cyc < budget) begin
            if (ram_req && ram_addr == watch) seen++;
            if (memory_ready) break;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int seen;
    int base;
    int rdy_cnt;

    initial begin
        rst_n            = 1'b0;
        mem_read         = 1'b0;
        mem_request_addr = 32'h0;
        mem_write        = 1'b0;
        mem_wb_addr      = 32'h0;
        mem_write_data   = 128'h0;
        rd_lat           = 0;
        stall_addr       = 32'hFFFF_FFFF;
        stall_cfg        = 0;
        stall_load       = 1'b0;
        spur_vld         = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready", memory_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram", {ram_req, ram_we, ram_addr, ram_wdata}, 0);
        chk("rst_mdata", memory_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // spurious rvalid in IDLE
        spur_vld = 1'b1;
        @(negedge clk);
        spur_vld = 1'b0;
        @(negedge clk);
        chk("spur_idle_mdata", memory_data, 0);
        chk("spur_idle_busy", busy, 0);

        // refill only
        base = log_addr.size();
        issue(1'b1, 32'h0000_1234, 1'b0, 32'h0, 128'h0);
        chk("rd_c1_req", {ram_req, ram_we, ram_addr}, {1'b1, 1'b0, 32'h0000_1230});
        wait_ready(1, 60, 32'hFFFF_FFFF, cyc, seen);
        chk("rd_cycle", cyc, 9);
        chk("rd_data", memory_data, 128'h000000A3_000000A2_000000A1_000000A0);
        for (int i = 0; i < 4; i++)
            chk("rd_log", {log_we[base+i], log_addr[base+i]}, {1'b0, 32'h0000_1230 + 32'(i*4)});
        @(negedge clk);
        chk("rd_pulse_end", {memory_ready, busy}, 2'b00);

        // write-back only, spurious rvalid during WB_REQ
        base = log_addr.size();
        issue(1'b0, 32'h0, 1'b1, 32'h0000_2008, 128'h00000044_00000033_00000022_00000011);
        chk("wb_c1_req", {ram_req, ram_we, ram_addr, ram_wdata},
            {1'b1, 1'b1, 32'h0000_2000, 32'h0000_0011});
        spur_vld = 1'b1;
        @(negedge clk);
        spur_vld = 1'b0;
        wait_ready(2, 60, 32'hFFFF_FFFF, cyc, seen);
        chk("wb_cycle", cyc, 5);
        chk("wb_mdata_kept", memory_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("wb_count", log_addr.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk("wb_log", {log_we[base+i], log_addr[base+i], log_data[base+i]},
                {1'b1, 32'h0000_2000 + 32'(i*4), 32'h11 * 32'(i+1)});
        @(negedge clk);
        chk("wb_pulse_end", {memory_ready, busy}, 2'b00);

        // simultaneous write-back and refill of the same block
        base = log_addr.size();
        issue(1'b1, 32'h0000_3000, 1'b1, 32'h0000_3000, 128'h000000C3_000000C2_000000C1_000000C0);
        wait_ready(1, 60, 32'hFFFF_FFFF, cyc, seen);
        chk("both_cycle", cyc, 13);
        chk("both_data", memory_data, 128'h000000C3_000000C2_000000C1_000000C0);
        for (int i = 0; i < 8; i++)
            chk("both_order", {log_we[base+i], log_addr[base+i]},
                {(i < 4) ? 1'b1 : 1'b0, 32'h0000_3000 + 32'((i % 4) * 4)});
        @(negedge clk);
        chk("both_single_pulse", memory_ready, 0);

        // refill with 3-cycle stall on word 2 and 4 extra cycles of read latency
        rd_lat     = 4;
        stall_addr = 32'h0000_1238;
        stall_cfg  = 3;
        stall_load = 1'b1;
        @(negedge clk);
        stall_load = 1'b0;
        issue(1'b1, 32'h0000_1230, 1'b0, 32'h0, 128'h0);
        wait_ready(1, 100, 32'h0000_1238, cyc, seen);
        chk("stall_cycle", cyc, 28);
        chk("stall_held", seen, 4);
        chk("stall_data", memory_data, 128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clk);
        stall_addr = 32'hFFFF_FFFF;
        rd_lat     = 0;

        // reset while waiting for read word 1
        issue(1'b1, 32'h0000_1230, 1'b0, 32'h0, 128'h0);
        repeat (3) @(negedge clk);
        chk("rst_mid_state", {busy, ram_req}, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", ram_req, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mdata", memory_data, 0);
        rst_n   = 1'b1;
        rdy_cnt = 0;
        if (memory_ready) rdy_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (memory_ready) rdy_cnt++;
        end
        chk("rst_mid_no_ready", rdy_cnt, 0);

        base = log_addr.size();
        issue(1'b1, 32'h0000_123C, 1'b0, 32'h0, 128'h0);
        wait_ready(1, 60, 32'hFFFF_FFFF, cyc, seen);
        chk("post_rst_cycle", cyc, 9);
        chk("post_rst_data", memory_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("post_rst_addr0", log_addr[base], 32'h0000_1230);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
